mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arb_pick.sv | 13 +
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding
// and the default starvation limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    localparam int unsigned STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection: data has priority unless the fetch port has been starved.
module mem_arb_pick (
    input  logic i_req,
    input  logic d_req,
    input  logic starve_hit,
    output logic pick_i,
    output logic pick_d
);

    assign pick_d = d_req && !(starve_hit && i_req);
    assign pick_i = i_req && !pick_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-outstanding memory
// port, with a starvation limit protecting the fetch side.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned DW         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_valid,
    output logic [DW-1:0]     i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DW-1:0]     d_wdata,
    input  logic [DW/8-1:0]   d_be,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DW-1:0]     d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_be,
    input  logic              mem_ack,
    input  logic [DW-1:0]     mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   be_q, be_d;

    logic busy_st, done, arb_en, starve_hit, pick_i, pick_d, gnt_i, gnt_d;

    assign busy_st    = (state_q != IDLE);
    assign done       = busy_st && mem_ack;
    // Grants are gated by reset so every output reads 0 while it is held.
    assign arb_en     = !reset && (!busy_st || mem_ack);
    assign starve_hit = (cnt_q == CNT_MAX);

    mem_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_hit (starve_hit),
        .pick_i     (pick_i),
        .pick_d     (pick_d)
    );

    assign gnt_i = arb_en && pick_i;
    assign gnt_d = arb_en && pick_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        if (gnt_i) begin
            state_d = BUSY_I;
            addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
            we_d    = 1'b0;
            wdata_d = '0;
            be_d    = '1;
        end else if (gnt_d) begin
            state_d = BUSY_D;
            addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
            we_d    = d_we;
            wdata_d = d_we ? d_wdata : '0;
            be_d    = d_we ? d_be : '1;
        end else if (done) begin
            state_d = IDLE;
        end
        if (arb_en) begin
            if (!i_req || gnt_i) begin
                cnt_d = '0;
            end else if (gnt_d && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    assign i_gnt     = gnt_i;
    assign d_gnt     = gnt_d;
    assign i_valid   = done && (state_q == BUSY_I);
    assign d_valid   = done && (state_q == BUSY_D);
    assign i_rdata   = i_valid ? mem_rdata : '0;
    assign d_rdata   = d_valid ? mem_rdata : '0;
    assign mem_req   = busy_st;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign busy      = busy_st;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level
// model of the arbiter that is checked on every falling clock edge.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SMAX = 4;

    logic          clk, reset;
    logic          i_req, i_gnt, i_valid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_gnt, d_valid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [3:0]    d_be;
    logic          mem_req, mem_we, mem_ack, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_be;

    mem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Model: the one outstanding memory transaction (kind 0=none,1=fetch,2=data)
    int          m_kind = 0;
    int          m_cnt  = 0;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    logic [3:0]  m_be;

    initial begin
        forever begin
            logic        pend, done, can, fetch_wins, eig, edg, eiv, edv;
            @(negedge clk);
            if (reset) begin
                chk("rst_mem_req", 64'(mem_req), 64'(0));
                chk("rst_i_gnt", 64'(i_gnt), 64'(0));
                chk("rst_d_gnt", 64'(d_gnt), 64'(0));
                chk("rst_i_valid", 64'(i_valid), 64'(0));
                chk("rst_d_valid", 64'(d_valid), 64'(0));
                chk("rst_i_rdata", 64'(i_rdata), 64'(0));
                chk("rst_d_rdata", 64'(d_rdata), 64'(0));
                chk("rst_mem_addr", 64'(mem_addr), 64'(0));
                chk("rst_busy", 64'(busy), 64'(0));
                m_kind = 0;
                m_cnt  = 0;
            end else begin
                pend = (m_kind != 0);
                chk("m_busy", 64'(busy), 64'(pend));
                chk("m_mem_req", 64'(mem_req), 64'(pend));
                if (pend) begin
                    chk("m_mem_addr", 64'(mem_addr), 64'(m_addr));
                    chk("m_mem_we", 64'(mem_we), 64'(m_we));
                    chk("m_mem_be", 64'(mem_be), 64'(m_be));
                    if (m_we) chk("m_mem_wdata", 64'(mem_wdata), 64'(m_wdata));
                end
                done = pend && mem_ack;
                eiv  = done && (m_kind == 1);
                edv  = done && (m_kind == 2);
                chk("m_i_valid", 64'(i_valid), 64'(eiv));
                chk("m_d_valid", 64'(d_valid), 64'(edv));
                chk("m_i_rdata", 64'(i_rdata), eiv ? 64'(mem_rdata) : 64'(0));
                chk("m_d_rdata", 64'(d_rdata), edv ? 64'(mem_rdata) : 64'(0));
                can        = !pend || mem_ack;
                fetch_wins = i_req && (!d_req || (m_cnt == SMAX));
                eig        = can && fetch_wins;
                edg        = can && d_req && !fetch_wins;
                chk("m_i_gnt", 64'(i_gnt), 64'(eig));
                chk("m_d_gnt", 64'(d_gnt), 64'(edg));
                if (eig) begin
                    m_kind = 1; m_addr = i_addr & ~32'h3; m_we = 1'b0; m_be = 4'hF; m_wdata = '0;
                end else if (edg) begin
                    m_kind = 2; m_addr = d_addr & ~32'h3; m_we = d_we;
                    m_be = d_we ? d_be : 4'hF; m_wdata = d_wdata;
                end else if (done) begin
                    m_kind = 0;
                end
                if (can) begin
                    if (!i_req || eig) m_cnt = 0;
                    else if (edg) m_cnt = (m_cnt + 1 > SMAX) ? SMAX : m_cnt + 1;
                end
            end
        end
    end

    initial begin
        logic gi, gd;
        int   ack_w;
        reset = 1'b1; i_req = 1'b1; i_addr = '0; d_req = 1'b1; d_we = 1'b0; d_addr = '0;
        d_wdata = '0; d_be = '0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_gnts", 64'({i_gnt, d_gnt}), 64'(0));
        chk("reset_valids", 64'({i_valid, d_valid}), 64'(0));
        chk("reset_mem_req", 64'(mem_req), 64'(0));
        reset = 1'b0; i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;

        // Lone fetch with immediate ack
        tick; i_req = 1'b1; i_addr = 32'h3000;
        #1 chk("lf_i_gnt", 64'(i_gnt), 64'(1));
        chk("lf_mem_req_n", 64'(mem_req), 64'(0));
        tick; i_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h24010001;
        #1 chk("lf_mem_addr", 64'(mem_addr), 64'h3000);
        chk("lf_i_valid", 64'(i_valid), 64'(1));
        chk("lf_i_rdata", 64'(i_rdata), 64'h24010001);
        tick; mem_ack = 1'b0;
        #1 chk("lf_idle", 64'(busy), 64'(0));

        // Contention: data store first, fetch granted in the data ack cycle
        tick; i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h6;
        d_be = 4'b1100; d_wdata = 32'hAABBCCDD;
        #1 chk("ct_d_gnt", 64'(d_gnt), 64'(1));
        chk("ct_i_gnt_n", 64'(i_gnt), 64'(0));
        tick; d_req = 1'b0; mem_ack = 1'b1;
        #1 chk("ct_mem_addr", 64'(mem_addr), 64'h4);
        chk("ct_mem_be", 64'(mem_be), 64'hC);
        chk("ct_mem_we", 64'(mem_we), 64'(1));
        chk("ct_mem_wdata", 64'(mem_wdata), 64'hAABBCCDD);
        chk("ct_d_valid", 64'(d_valid), 64'(1));
        chk("ct_i_gnt", 64'(i_gnt), 64'(1));
        tick; i_req = 1'b0;
        #1 chk("ct_i_valid", 64'(i_valid), 64'(1));
        chk("ct_mem_addr2", 64'(mem_addr), 64'h100);
        chk("ct_mem_be2", 64'(mem_be), 64'hF);
        tick; mem_ack = 1'b0;

        // Starvation: d,d,d,d,i then the counter restarts: d,d,d,d,i
        tick; i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        mem_ack = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("sv_i_gnt%0d", k), 64'(i_gnt), 64'((k == 4) || (k == 9)));
            chk($sformatf("sv_d_gnt%0d", k), 64'(d_gnt), 64'(!((k == 4) || (k == 9))));
            tick;
        end
        i_req = 1'b0; d_req = 1'b0;
        #1 chk("sv_last_i_valid", 64'(i_valid), 64'(1));
        tick; mem_ack = 1'b0;
        #1 chk("sv_idle", 64'(busy), 64'(0));

        // Waited memory: three stall cycles before ack
        tick; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_be = 4'b0011; d_wdata = 32'h11223344;
        #1 chk("wm_d_gnt", 64'(d_gnt), 64'(1));
        tick; d_req = 1'b0; i_req = 1'b1; i_addr = 32'h404;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("wm_fields", 64'({mem_req, mem_we, mem_be, mem_addr}), {27'd0, 1'b1, 1'b1, 4'h3, 32'h20});
            chk("wm_wdata", 64'(mem_wdata), 64'h11223344);
            chk("wm_no_gnt", 64'({i_gnt, d_gnt}), 64'(0));
            chk("wm_no_valid", 64'(d_valid), 64'(0));
            tick;
        end
        mem_ack = 1'b1;
        #1 chk("wm_d_valid", 64'(d_valid), 64'(1));
        chk("wm_i_gnt", 64'(i_gnt), 64'(1));
        tick; i_req = 1'b0;
        #1 chk("wm_i_valid", 64'(i_valid), 64'(1));
        tick; mem_ack = 1'b0;

        // Reset in BUSY_D before ack
        tick; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        #1 chk("rm_d_gnt", 64'(d_gnt), 64'(1));
        tick; d_req = 1'b0;
        #1 chk("rm_mem_req", 64'(mem_req), 64'(1));
        #1 reset = 1'b1; mem_ack = 1'b1;
        #1 chk("rm_mem_req_n", 64'(mem_req), 64'(0));
        chk("rm_busy_n", 64'(busy), 64'(0));
        chk("rm_d_valid_n", 64'(d_valid), 64'(0));
        tick; reset = 1'b0; mem_ack = 1'b0;
        tick; d_req = 1'b1; d_addr = 32'h48;
        #1 chk("rm_regnt", 64'(d_gnt), 64'(1));
        tick; d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1 chk("rm_mem_addr", 64'(mem_addr), 64'h48);
        chk("rm_d_valid", 64'(d_valid), 64'(1));
        chk("rm_d_rdata", 64'(d_rdata), 64'hCAFEF00D);
        tick; mem_ack = 1'b0;

        // Spurious ack while idle
        tick; mem_ack = 1'b1;
        #1 chk("sp_valid", 64'({i_valid, d_valid}), 64'(0));
        chk("sp_busy", 64'(busy), 64'(0));
        tick;
        #1 chk("sp_busy2", 64'(busy), 64'(0));
        mem_ack = 1'b0;

        // Randomized traffic; requesters hold requests and fields until granted
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            gi = i_gnt;
            gd = d_gnt;
            @(posedge clk);
            #1;
            ack_w = 1 + (c / 1000);
            reset = ($urandom_range(0, 299) == 0);
            if (!i_req || gi) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = $urandom;
            end
            if (!d_req || gd) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom);
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_be    = 4'($urandom);
            end
            mem_ack   = ($urandom_range(0, 3) < ack_w);
            mem_rdata = $urandom;
        end
        tick; reset = 1'b0; i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        repeat (2) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
